dot_update_scheduler: RTL and testbench

Sits between the processor's dot-location write port and the VGA controller's dot register file (dotWren / is_Yloc / dotID / dotLoc).
- Buffers processor dot writes in a FIFO.
- Validates and clamps each entry.
- Replays entries to the VGA controller only during vertical blanking, so dots never tear mid-frame.
- Signals the processor once per frame when the drain has finished.

---
 rtl/dot_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/dot_update_scheduler.sv | 144 ++++++++++++++
 tb/tb_dot_update_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared constants, FSM encoding and coordinate clamp for the dot update scheduler.
package dot_pkg;

  localparam int NUM_DOTS    = 200;
  localparam int ID_W        = 8;
  localparam int LOC_W       = 10;
  localparam int X_MAX       = 639;
  localparam int Y_MAX       = 479;
  localparam int FIFO_DEPTH  = 256;
  localparam int HOLD_CYCLES = 4;
  localparam int ENTRY_W     = 1 + ID_W + LOC_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // The full 32-bit value is compared so that bits above the stored width still saturate.
  function automatic logic [LOC_W-1:0] clamp_loc(input logic [31:0] loc,
                                                 input logic [LOC_W-1:0] max_loc);
    logic [LOC_W-1:0] result;
    result = (loc > 32'(max_loc)) ? max_loc : loc[LOC_W-1:0];
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dot_update_scheduler.sv
// Buffers processor dot writes and replays them to the VGA dot registers only during
// vertical blanking, pulsing frame_done once per frame when the drain is finished.
module dot_update_scheduler #(
  parameter int NUM_DOTS    = dot_pkg::NUM_DOTS,
  parameter int ID_W        = dot_pkg::ID_W,
  parameter int FIFO_DEPTH  = dot_pkg::FIFO_DEPTH,
  parameter int HOLD_CYCLES = dot_pkg::HOLD_CYCLES,
  parameter int X_MAX       = dot_pkg::X_MAX,
  parameter int Y_MAX       = dot_pkg::Y_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wren,
  input  logic        cpu_is_yloc,
  input  logic [31:0] cpu_dot_id,
  input  logic [31:0] cpu_dot_loc,
  output logic        cpu_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic [15:0] drop_count,
  input  logic        screen_end,
  output logic        dot_wren,
  output logic        dot_is_yloc,
  output logic [31:0] dot_id,
  output logic [31:0] dot_loc
);

  import dot_pkg::*;

  localparam int ENT_W = 1 + ID_W + LOC_W;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t           state;
  state_t           state_next;
  logic             screen_end_q;
  logic             screen_end_rise;
  logic             id_valid;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LOC_W-1:0] loc_clamped;
  logic [ENT_W-1:0] fifo_din;
  logic [ENT_W-1:0] fifo_dout;
  logic [CNT_W-1:0] hold_cnt;
  logic             out_is_yloc;
  logic [ID_W-1:0]  out_id;
  logic [LOC_W-1:0] out_loc;

  assign id_valid        = (cpu_dot_id < 32'(NUM_DOTS));
  assign loc_clamped     = clamp_loc(cpu_dot_loc, cpu_is_yloc ? LOC_W'(Y_MAX) : LOC_W'(X_MAX));
  assign fifo_din        = {cpu_is_yloc, cpu_dot_id[ID_W-1:0], loc_clamped};
  assign push            = cpu_wren && !fifo_full && id_valid;
  assign cpu_ready       = !fifo_full;
  assign screen_end_rise = screen_end && !screen_end_q;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      screen_end_q <= 1'b0;
    end else begin
      screen_end_q <= screen_end;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Blanking rises seen outside IDLE are ignored, so one drain runs per frame at most.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (screen_end_rise) state_next = DRAIN;
      DRAIN:   state_next = fifo_empty ? DONE : HOLD;
      HOLD:    if (hold_cnt == '0) state_next = DRAIN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop        = 1'b0;
    dot_wren   = 1'b0;
    frame_done = 1'b0;
    case (state)
      DRAIN:   pop = !fifo_empty;
      HOLD:    dot_wren = 1'b1;
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  // The head entry is latched on pop and held steady for a full pixel-clock period.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt    <= '0;
      out_is_yloc <= 1'b0;
      out_id      <= '0;
      out_loc     <= '0;
    end else if (pop) begin
      hold_cnt                         <= CNT_W'(HOLD_CYCLES - 1);
      {out_is_yloc, out_id, out_loc}   <= fifo_dout;
    end else if ((state == HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (cpu_wren && id_valid && fifo_full) begin
        overflow <= 1'b1;
      end
      if (cpu_wren && !id_valid && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  assign dot_is_yloc = out_is_yloc;
  assign dot_id      = 32'(out_id);
  assign dot_loc     = 32'(out_loc);

endmodule

// File: tb/tb_dot_update_scheduler.sv
// Directed bench for dot_update_scheduler; a monitor pops expected replays and frame ticks
// from a scoreboard queue as the DUT presents them.
module tb_dot_update_scheduler;

  typedef struct packed {
    logic        is_frame;
    logic        is_yloc;
    logic [31:0] id;
    logic [31:0] loc;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        cpu_wren;
  logic        cpu_is_yloc;
  logic [31:0] cpu_dot_id;
  logic [31:0] cpu_dot_loc;
  logic        cpu_ready;
  logic        frame_done;
  logic        overflow;
  logic [15:0] drop_count;
  logic        screen_end;
  logic        dot_wren;
  logic        dot_is_yloc;
  logic [31:0] dot_id;
  logic [31:0] dot_loc;

  int   vectors = 0;
  int   errors  = 0;
  exp_t exp_q[$];
  logic prev_wren = 1'b0;
  int   hold_len  = 0;

  dot_update_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_wren    (cpu_wren),
    .cpu_is_yloc (cpu_is_yloc),
    .cpu_dot_id  (cpu_dot_id),
    .cpu_dot_loc (cpu_dot_loc),
    .cpu_ready   (cpu_ready),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .screen_end  (screen_end),
    .dot_wren    (dot_wren),
    .dot_is_yloc (dot_is_yloc),
    .dot_id      (dot_id),
    .dot_loc     (dot_loc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drives one processor write for a cycle; queues the replay the VGA side should see.
  task automatic applyStimulus(input logic [31:0] id, input logic yloc, input logic [31:0] loc,
                               input logic [31:0] exp_loc, input bit exp_replay);
    exp_t e;
    cpu_wren    = 1'b1;
    cpu_dot_id  = id;
    cpu_is_yloc = yloc;
    cpu_dot_loc = loc;
    if (exp_replay) begin
      e          = '0;
      e.is_yloc  = yloc;
      e.id       = id;
      e.loc      = exp_loc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    cpu_wren = 1'b0;
  endtask

  task automatic pushFrame();
    exp_t e;
    e          = '0;
    e.is_frame = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_complete", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic blankAndDrain(input int budget);
    pushFrame();
    screen_end = 1'b1;
    waitDrain(budget);
    screen_end = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every dot_wren rise and every frame_done pulse consumes one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_wren = 1'b0;
      hold_len  = 0;
    end else begin
      if (dot_wren && !prev_wren) begin
        hold_len = 1;
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_dot: got write id %0d loc %0d, required none", dot_id, dot_loc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_kind_dot", 32'd0, 32'(e.is_frame));
          if (!e.is_frame) begin
            checkOutput("replay_id", dot_id, e.id);
            checkOutput("replay_axis", 32'(dot_is_yloc), 32'(e.is_yloc));
            checkOutput("replay_loc", dot_loc, e.loc);
          end
        end
      end else if (dot_wren && prev_wren) begin
        hold_len++;
      end else if (!dot_wren && prev_wren) begin
        checkOutput("hold_len", hold_len, 4);
      end
      if (frame_done) begin
        if (exp_q.size() == 0) begin
          vectors++;
          errors++;
          $display("[TB] FAIL unexpected_frame_done: got pulse, required none");
        end else begin
          e = exp_q.pop_front();
          checkOutput("event_kind_frame", 32'd1, 32'(e.is_frame));
        end
      end
      prev_wren = dot_wren;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit wexp[14];
    bit fexp[14];
    wexp = '{0, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 0, 0};
    fexp = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    reset       = 1'b1;
    cpu_wren    = 1'b0;
    cpu_is_yloc = 1'b0;
    cpu_dot_id  = '0;
    cpu_dot_loc = '0;
    screen_end  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_cpu_ready", 32'(cpu_ready), 1);
    checkOutput("reset_dot_wren", 32'(dot_wren), 0);
    checkOutput("reset_frame_done", 32'(frame_done), 0);
    checkOutput("reset_overflow", 32'(overflow), 0);
    checkOutput("reset_drop_count", 32'(drop_count), 0);
    checkOutput("reset_dot_id", dot_id, 0);
    checkOutput("reset_dot_loc", dot_loc, 0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("idle_frame_done", 32'(frame_done), 0);

    // Basic replay with cycle-exact timing relative to the blanking edge.
    applyStimulus(5, 1'b0, 100, 100, 1'b1);
    applyStimulus(5, 1'b1, 50, 50, 1'b1);
    pushFrame();
    screen_end = 1'b1;
    for (int i = 1; i < 14; i++) begin
      @(negedge clk);
      checkOutput($sformatf("timing_wren_T%0d", i), 32'(dot_wren), 32'(wexp[i]));
      checkOutput($sformatf("timing_frame_T%0d", i), 32'(frame_done), 32'(fexp[i]));
    end
    screen_end = 1'b0;
    @(negedge clk);
    checkOutput("basic_queue_empty", exp_q.size(), 0);

    // Invalid IDs are dropped; an empty frame still ticks.
    applyStimulus(250, 1'b0, 10, 0, 1'b0);
    checkOutput("drop_count_1", 32'(drop_count), 1);
    blankAndDrain(20);
    applyStimulus(200, 1'b0, 10, 0, 1'b0);
    applyStimulus(199, 1'b0, 0, 0, 1'b1);
    checkOutput("drop_count_2", 32'(drop_count), 2);
    blankAndDrain(40);

    // Clamping, including bits beyond the stored coordinate width.
    applyStimulus(3, 1'b0, 700, 639, 1'b1);
    applyStimulus(3, 1'b1, 500, 479, 1'b1);
    applyStimulus(7, 1'b0, 32'h0000_0400, 639, 1'b1);
    applyStimulus(7, 1'b1, 480, 479, 1'b1);
    applyStimulus(8, 1'b0, 639, 639, 1'b1);
    applyStimulus(8, 1'b1, 479, 479, 1'b1);
    applyStimulus(9, 1'b0, 32'h0001_0005, 639, 1'b1);
    blankAndDrain(100);

    // A write landing mid-drain is replayed in the same frame.
    applyStimulus(10, 1'b0, 11, 11, 1'b1);
    screen_end = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(11, 1'b1, 22, 22, 1'b1);
    pushFrame();
    waitDrain(100);
    screen_end = 1'b0;
    @(negedge clk);

    // Fill to capacity, overflow, then drain everything in order.
    for (int i = 0; i < 256; i++) begin
      if (i == 255) checkOutput("ready_at_255", 32'(cpu_ready), 1);
      applyStimulus(32'(i % 200), i[0], 32'(i), 32'(i), 1'b1);
    end
    checkOutput("full_ready", 32'(cpu_ready), 0);
    checkOutput("full_no_overflow_yet", 32'(overflow), 0);
    applyStimulus(1, 1'b0, 5, 0, 1'b0);
    checkOutput("overflow_set", 32'(overflow), 1);
    applyStimulus(300, 1'b0, 5, 0, 1'b0);
    checkOutput("drop_count_full", 32'(drop_count), 3);
    blankAndDrain(2000);
    checkOutput("ready_after_drain", 32'(cpu_ready), 1);
    checkOutput("overflow_sticky", 32'(overflow), 1);

    // Reset during the hold of the second of ten entries aborts the drain.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(32'(20 + i), 1'b0, 32'(i * 3), 32'(i * 3), (i < 2));
    end
    screen_end = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("pre_reset_wren", 32'(dot_wren), 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("abort_dot_wren", 32'(dot_wren), 0);
    checkOutput("abort_cpu_ready", 32'(cpu_ready), 1);
    checkOutput("abort_overflow", 32'(overflow), 0);
    checkOutput("abort_drop_count", 32'(drop_count), 0);
    checkOutput("abort_dot_id", dot_id, 0);
    checkOutput("abort_replays", exp_q.size(), 0);
    screen_end = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    blankAndDrain(40);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
